// File: rtl/reg_file_dump.sv
// MIPS register file (two combinational read ports, one clocked write port) with a
// debug dump engine that streams a register range one beat per accepted transfer.
module reg_file_dump #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DUMP_FIRST = 0,
  parameter int unsigned DUMP_LAST  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  input  logic [ADDR_W-1:0] r3_addr,
  input  logic [DATA_W-1:0] r3_in,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] r1_out,
  output logic [DATA_W-1:0] r2_out,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int unsigned       NumRegs   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FirstIdx  = ADDR_W'(DUMP_FIRST);
  localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(DUMP_LAST);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, idx_inc;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] regs_q [NumRegs];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (RegWrite && (r3_addr != '0)) begin
      regs_q[r3_addr] <= r3_in;
    end
  end

  // No write-to-read bypass: a bypass would close a combinational loop through the ALU.
  assign r1_out = (r1_addr == '0) ? '0 : regs_q[r1_addr];
  assign r2_out = (r2_addr == '0) ? '0 : regs_q[r2_addr];

  assign idx_inc = idx_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (dump_req) begin
          state_d = StScan;
          idx_d   = FirstIdx;
          data_d  = (FirstIdx == '0) ? '0 : regs_q[FirstIdx];
        end
      end
      StScan: begin
        if (dump_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d  = idx_inc;
            // Snapshot taken from pre-edge contents; later writes cannot disturb it.
            data_d = regs_q[idx_inc];
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign dump_valid = (state_q == StScan);
  assign dump_busy  = (state_q != StIdle);
  assign dump_done  = (state_q == StDone);
  assign dump_addr  = idx_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: register reads/writes and dump stream behaviour.
module tb_reg_file_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  r1_addr, r2_addr, r3_addr;
  logic [31:0] r3_in;
  logic        RegWrite;
  logic [31:0] r1_out, r2_out;
  logic        dump_req, dump_ready;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_busy, dump_done;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_reg [32];
  logic [31:0] exp_cur;
  int          b;

  reg_file_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r1_addr    (r1_addr),
    .r2_addr    (r2_addr),
    .r3_addr    (r3_addr),
    .r3_in      (r3_in),
    .RegWrite   (RegWrite),
    .r1_out     (r1_out),
    .r2_out     (r2_out),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    RegWrite = 1'b1;
    r3_addr  = 5'(a);
    r3_in    = d;
    step();
    RegWrite = 1'b0;
    if (a != 0) exp_reg[a] = d;
  endtask

  task automatic check_dump_full(input string tag);
    for (int i = 0; i < 32; i++) begin
      check({tag, "_valid"}, 32'(dump_valid), 32'd1);
      check({tag, "_addr"}, 32'(dump_addr), 32'(i));
      check({tag, "_data"}, dump_data, exp_reg[i]);
      step();
    end
    check({tag, "_done"}, 32'(dump_done), 32'd1);
    check({tag, "_done_busy"}, 32'(dump_busy), 32'd1);
    check({tag, "_done_valid"}, 32'(dump_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; r1_addr = '0; r2_addr = '0; r3_addr = '0; r3_in = '0;
    RegWrite = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) exp_reg[i] = '0;
    #1;
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_busy", 32'(dump_busy), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    check("rst_addr", 32'(dump_addr), 32'd0);
    check("rst_data", dump_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // T1: all zero after reset; r0 write discarded
    for (int i = 0; i < 32; i++) begin
      r1_addr = 5'(i);
      r2_addr = 5'(31 - i);
      #1;
      check("t1_r1", r1_out, 32'd0);
      check("t1_r2", r2_out, 32'd0);
    end
    r1_addr = 5'd0;
    write_reg(0, 32'hDEADBEEF);
    check("t1_r0", r1_out, 32'd0);

    // T2: no bypass before the edge, visible after
    r1_addr = 5'd5; r2_addr = 5'd5;
    RegWrite = 1'b1; r3_addr = 5'd5; r3_in = 32'h12345678;
    #1;
    check("t2_before", r1_out, 32'd0);
    step();
    RegWrite = 1'b0;
    exp_reg[5] = 32'h12345678;
    check("t2_r1", r1_out, 32'h12345678);
    check("t2_r2", r2_out, 32'h12345678);

    // T3: full dump with ready held high
    for (int i = 1; i < 32; i++) write_reg(i, {4{8'(i)}});
    dump_ready = 1'b1;
    dump_req = 1'b1;
    check("t3_idle_busy", 32'(dump_busy), 32'd0);
    step();
    dump_req = 1'b0;
    check_dump_full("t3");
    step();
    check("t3_post_done", 32'(dump_done), 32'd0);
    check("t3_post_busy", 32'(dump_busy), 32'd0);

    // T4: ready toggling; r7 written while beat 7 stalls
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    b = 0;
    exp_cur = exp_reg[0];
    for (int c = 0; c < 100 && b < 32; c++) begin
      dump_ready = (c % 2 == 0);
      RegWrite   = (b == 7) && !dump_ready;
      r3_addr    = 5'd7;
      r3_in      = 32'hFFFFFFFF;
      check("t4_valid", 32'(dump_valid), 32'd1);
      check("t4_addr", 32'(dump_addr), 32'(b));
      check("t4_data", dump_data, exp_cur);
      step();
      if (RegWrite) exp_reg[7] = 32'hFFFFFFFF;
      RegWrite = 1'b0;
      if (dump_ready) begin
        b++;
        if (b < 32) exp_cur = exp_reg[b];
      end
    end
    check("t4_beats", 32'(b), 32'd32);
    check("t4_done", 32'(dump_done), 32'd1);
    r1_addr = 5'd7;
    #1;
    check("t4_r7", r1_out, 32'hFFFFFFFF);
    step();
    check("t4_post_done", 32'(dump_done), 32'd0);

    // T5: async reset mid-dump at beat 10
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t5_addr10", 32'(dump_addr), 32'd10);
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(dump_valid), 32'd0);
    check("t5_busy", 32'(dump_busy), 32'd0);
    check("t5_addr", 32'(dump_addr), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_done", 32'(dump_done), 32'd0);
      check("t5_idle", 32'(dump_busy), 32'd0);
      step();
    end
    for (int i = 0; i < 32; i++) begin
      exp_reg[i] = '0;
      r1_addr = 5'(i);
      #1;
      check("t5_reg", r1_out, 32'd0);
    end

    // T6: req held high through a dump
    write_reg(1, 32'h11111111);
    write_reg(31, 32'hA5A5A5A5);
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    check_dump_full("t6a");
    step();
    check("t6_idle_busy", 32'(dump_busy), 32'd0);
    check("t6_idle_valid", 32'(dump_valid), 32'd0);
    step();
    dump_req = 1'b0;
    check_dump_full("t6b");
    step();
    check("t6_end_busy", 32'(dump_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
